// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding, add-3 constants and digit-count helper for bin_to_bcd_seq.
`default_nettype none

package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Smallest digit count d with 10^d >= 2^width.
  function automatic int min_digits(input int width);
    logic [255:0] lim;
    logic [255:0] p;
    int           d;
    lim = 256'd1 << width;
    p   = 256'd10;
    d   = 1;
    for (int i = 0; i < 76; i++) begin
      if (p < lim) begin
        p = p * 256'd10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: one double-dabble cell, adds 3 to a BCD digit that is 5 or more.
`default_nettype none

module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       unused_i,
  output logic [3:0] digit_o
);

  logic unused_w;
  assign unused_w = unused_i;

  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
`default_nettype none

module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int CAT_W = 4 * DIGITS + WIDTH;

  if (WIDTH < 2) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be at least 2");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small to hold 2^WIDTH-1");
  end

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                neg_q;
  logic                sign_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WIDTH-1:0]    shift_q;
  logic [WIDTH-1:0]    shift_d;
  logic [4*DIGITS-1:0] scratch_q;
  logic [4*DIGITS-1:0] scratch_d;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] scratch_adj;
  logic [CAT_W-1:0]    cat_d;
  logic [WIDTH-1:0]    bin_mag;
  logic                bin_sign;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i  (scratch_q[4*g +: 4]),
      .unused_i (1'b0),
      .digit_o  (scratch_adj[4*g +: 4])
    );
  end

  assign cat_d     = {scratch_adj, shift_q} << 1;
  assign scratch_d = cat_d[CAT_W-1:WIDTH];
  assign shift_d   = cat_d[WIDTH-1:0];

`ifdef BIN2BCD_SIGNED_EN
  // Most negative input wraps to 2^(WIDTH-1), which is the correct magnitude unsigned.
  assign bin_sign = bin[WIDTH-1];
  assign bin_mag  = bin_sign ? (~bin + 1'b1) : bin;
`else
  assign bin_sign = 1'b0;
  assign bin_mag  = bin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin_mag;
            sign_q    <= bin_sign;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            bcd_q   <= scratch_d;
            neg_q   <= sign_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign neg  = neg_q;

endmodule

`default_nettype wire
